// File: rtl/pix_fetch.sv
// Pixel fetch unit: on a trigger edge, reads the packed memory word holding pixel (x,y,z) and returns it.
// Optional one-entry last-word cache enabled by defining PIXFETCH_WORD_CACHE_EN.
module pix_fetch #(
  parameter int IMG_W       = 4,
  parameter int IMG_H       = 4,
  parameter int CHANNELS    = 3,
  parameter int PIX_WIDTH   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int BASE_ADDR   = 0,
  parameter int HOLD_CYCLES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic signed [31:0]    x,
  input  logic signed [31:0]    y,
  input  logic signed [31:0]    z,
  input  logic                  trigger,
  input  logic                  data_ready_mem,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  we,
  output logic                  csb,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [PIX_WIDTH-1:0]  p,
  output logic                  data_ready_cpu,
  output logic                  err,
  output logic                  busy
);

  localparam int PPW    = DATA_WIDTH / PIX_WIDTH;
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             state, state_next;
  logic               trigger_prev;
  logic signed [31:0] x_q, y_q, z_q;
  logic [LANE_W-1:0]  lane_q;
  logic [31:0]        wait_cnt;
  logic [31:0]        hold_cnt;

  logic               start;
  logic               in_range;
  logic               hit;
  logic [31:0]        idx;
  logic [31:0]        word_full;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic [LANE_W-1:0]  lane_calc;
  logic               wait_expired;
  logic               hold_last;

  function automatic logic [PIX_WIDTH-1:0] lane_pix(input logic [DATA_WIDTH-1:0] word,
                                                    input logic [LANE_W-1:0]     lane);
    lane_pix = word[int'(lane)*PIX_WIDTH +: PIX_WIDTH];
  endfunction

  assign start        = trigger && !trigger_prev;
  assign in_range     = (x_q >= 0) && (x_q < IMG_W) &&
                        (y_q >= 0) && (y_q < IMG_H) &&
                        (z_q >= 0) && (z_q < CHANNELS);
  assign idx          = $unsigned((z_q * IMG_H + y_q) * IMG_W + x_q);
  assign word_full    = $unsigned(BASE_ADDR) + idx / PPW;
  assign addr_calc    = word_full[ADDR_WIDTH-1:0];
  assign lane_calc    = LANE_W'(idx % PPW);
  assign wait_expired = (wait_cnt == 32'(TIMEOUT - 1));
  assign hold_last    = (hold_cnt == 32'(HOLD_CYCLES - 1));

`ifdef PIXFETCH_WORD_CACHE_EN
  logic                  cache_valid;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_data;

  assign hit = cache_valid && (cache_addr == addr_calc);

  // NOTE: only the valid bit truly needs reset; tag/data are cleared too so reset state is fully defined.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
    end else if (state == S_WAIT && data_ready_mem) begin
      cache_valid <= 1'b1;
      cache_addr  <= addr;
      cache_data  <= data_out;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_CALC;
      S_CALC: state_next = (!in_range || hit) ? S_DONE : S_REQ;
      S_REQ:  state_next = S_WAIT;
      S_WAIT: if (data_ready_mem || wait_expired) state_next = S_DONE;
      S_DONE: if (hold_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      trigger_prev <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      lane_q       <= '0;
      wait_cnt     <= '0;
      hold_cnt     <= '0;
      addr         <= '0;
      p            <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_next;
      trigger_prev <= trigger;
      case (state)
        S_IDLE: begin
          hold_cnt <= '0;
          if (start) begin
            x_q <= x;
            y_q <= y;
            z_q <= z;
          end
        end
        S_CALC: begin
          if (!in_range) begin
            p   <= '0;
            err <= 1'b1;
          end else begin
            addr   <= addr_calc;
            lane_q <= lane_calc;
`ifdef PIXFETCH_WORD_CACHE_EN
            if (hit) begin
              p   <= lane_pix(cache_data, lane_calc);
              err <= 1'b0;
            end
`endif
          end
        end
        S_REQ: wait_cnt <= '0;
        S_WAIT: begin
          if (data_ready_mem) begin
            p   <= lane_pix(data_out, lane_q);
            err <= 1'b0;
          end else if (wait_expired) begin
            p   <= '0;
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_DONE: hold_cnt <= hold_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  assign we             = 1'b0;
  assign csb            = (state != S_REQ);
  assign busy           = (state != S_IDLE);
  assign data_ready_cpu = (state == S_DONE);

endmodule

// File: tb/tb_pix_fetch.sv
// Directed self-checking bench for pix_fetch (4x4x3 image, 4-bit pixels, 16-bit words, base 0x10).
// Cache expectations follow PIXFETCH_WORD_CACHE_EN when it is defined.
module tb_pix_fetch;

  localparam int HOLD    = 2;
  localparam int TMO     = 15;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  int          x = 0, y = 0, z = 0;
  logic        trigger = 1'b0;
  logic        drm = 1'b0;
  logic [15:0] data_out = '0;
  logic        we, csb, data_ready_cpu, err, busy;
  logic [7:0]  addr;
  logic [3:0]  p;

  int checks = 0;
  int failures = 0;
  int csb_cnt = 0;
  int drdy_cnt = 0;

  pix_fetch #(
    .IMG_W(4), .IMG_H(4), .CHANNELS(3), .PIX_WIDTH(4), .DATA_WIDTH(16),
    .ADDR_WIDTH(8), .BASE_ADDR('h10), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .rst(rst), .x(x), .y(y), .z(z), .trigger(trigger),
    .data_ready_mem(drm), .data_out(data_out), .we(we), .csb(csb), .addr(addr),
    .p(p), .data_ready_cpu(data_ready_cpu), .err(err), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!csb) csb_cnt++;
    if (data_ready_cpu) drdy_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one fetch, answering the memory one cycle after the csb pulse when respond is set.
  // lat is the cycle index (start edge = cycle 0) where data_ready_cpu is first seen, -1 if never.
  task automatic do_fetch(input int fx, input int fy, input int fz, input logic [15:0] word,
                          input bit respond, output int lat, output int csb_n, output int drdy_n);
    int c0, d0;
    bit pending, done;
    c0 = csb_cnt; d0 = drdy_cnt; lat = -1; pending = 0; done = 0;
    x = fx; y = fy; z = fz; data_out = word; trigger = 1'b1;
    for (int n = 1; n <= 60 && !done; n++) begin
      tick();
      drm = pending;
      pending = 0;
      if (!csb && respond) pending = 1;
      if (data_ready_cpu && lat < 0) lat = n;
      if (lat >= 0 && !busy) done = 1;
    end
    trigger = 1'b0; drm = 1'b0;
    tick();
    csb_n = csb_cnt - c0;
    drdy_n = drdy_cnt - d0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (csb !== 1'b1) begin failures++; $display("FAIL reset_csb got %b exp 1", csb); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got %b exp 0", we); end
    checks++; if (addr !== 8'h00) begin failures++; $display("FAIL reset_addr got %h exp 00", addr); end
    checks++; if (p !== 4'h0) begin failures++; $display("FAIL reset_p got %h exp 0", p); end
    checks++; if (data_ready_cpu !== 1'b0) begin failures++; $display("FAIL reset_drdy got %b exp 0", data_ready_cpu); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic(input int fx, input int fy, input int fz, input logic [15:0] word,
                            input logic [7:0] exp_addr, input logic [3:0] exp_p);
    int lat, cn, dn;
    do_fetch(fx, fy, fz, word, 1, lat, cn, dn);
    checks++; if (addr !== exp_addr) begin failures++; $display("FAIL basic_addr got %h exp %h", addr, exp_addr); end
    checks++; if (cn !== 1) begin failures++; $display("FAIL basic_csb_cycles got %0d exp 1", cn); end
    checks++; if (p !== exp_p) begin failures++; $display("FAIL basic_p got %h exp %h", p, exp_p); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got %b exp 0", err); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got %0d exp 4", lat); end
    checks++; if (dn !== HOLD) begin failures++; $display("FAIL basic_drdy_cycles got %0d exp %0d", dn, HOLD); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL basic_we got %b exp 0", we); end
  endtask

  task automatic test_out_of_range(input int fx, input int fy, input int fz);
    int lat, cn, dn;
    do_fetch(fx, fy, fz, 16'hFFFF, 1, lat, cn, dn);
    checks++; if (cn !== 0) begin failures++; $display("FAIL oor_csb_cycles (%0d,%0d,%0d) got %0d exp 0", fx, fy, fz, cn); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_err (%0d,%0d,%0d) got %b exp 1", fx, fy, fz, err); end
    checks++; if (p !== 4'h0) begin failures++; $display("FAIL oor_p (%0d,%0d,%0d) got %h exp 0", fx, fy, fz, p); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL oor_latency (%0d,%0d,%0d) got %0d exp 2", fx, fy, fz, lat); end
  endtask

  task automatic test_timeout();
    int lat, cn, dn;
    do_fetch(2, 3, 2, 16'h0000, 0, lat, cn, dn);
    // CALC at 1, REQ at 2, TMO WAIT cycles at 3..TMO+2, DONE at TMO+3.
    checks++; if (lat !== TMO + 3) begin failures++; $display("FAIL timeout_latency got %0d exp %0d", lat, TMO + 3); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_err got %b exp 1", err); end
    checks++; if (p !== 4'h0) begin failures++; $display("FAIL timeout_p got %h exp 0", p); end
    checks++; if (addr !== 8'h1B) begin failures++; $display("FAIL timeout_addr got %h exp 1b", addr); end
    checks++; if (cn !== 1) begin failures++; $display("FAIL timeout_csb_cycles got %0d exp 1", cn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_edge_handling();
    int c0, d0;
    x = 0; y = 0; z = 0; data_out = 16'h1234; drm = 1'b1;
    c0 = csb_cnt; d0 = drdy_cnt;
    trigger = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1) trigger = 1'b0;
      if (i == 2) trigger = 1'b1;
    end
    trigger = 1'b0; drm = 1'b0;
    tick();
    checks++; if (csb_cnt - c0 !== 1) begin failures++; $display("FAIL edge_csb_cycles got %0d exp 1", csb_cnt - c0); end
    checks++; if (drdy_cnt - d0 !== HOLD) begin failures++; $display("FAIL edge_drdy_cycles got %0d exp %0d", drdy_cnt - d0, HOLD); end
    checks++; if (p !== 4'h4) begin failures++; $display("FAIL edge_p got %h exp 4", p); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL edge_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_during_wait();
    int d0;
    x = 1; y = 1; z = 1; data_out = 16'hFFFF; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstwait_busy_before got %b exp 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstwait_busy got %b exp 0", busy); end
    checks++; if (csb !== 1'b1) begin failures++; $display("FAIL rstwait_csb got %b exp 1", csb); end
    checks++; if (addr !== 8'h00) begin failures++; $display("FAIL rstwait_addr got %h exp 00", addr); end
    checks++; if (p !== 4'h0) begin failures++; $display("FAIL rstwait_p got %h exp 0", p); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstwait_err got %b exp 0", err); end
    tick();
    rst = 1'b0;
    d0 = drdy_cnt;
    drm = 1'b1;
    tick();
    drm = 1'b0;
    repeat (5) tick();
    checks++; if (drdy_cnt - d0 !== 0) begin failures++; $display("FAIL rstwait_drdy_cycles got %0d exp 0", drdy_cnt - d0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstwait_busy_after got %b exp 0", busy); end
    checks++; if (p !== 4'h0) begin failures++; $display("FAIL rstwait_p_after got %h exp 0", p); end
  endtask

  task automatic test_cache();
    int lat, cn, dn;
    do_fetch(0, 0, 0, 16'hB7E1, 1, lat, cn, dn);
    checks++; if (p !== 4'h1) begin failures++; $display("FAIL cache_first_p got %h exp 1", p); end
    checks++; if (cn !== 1) begin failures++; $display("FAIL cache_first_csb got %0d exp 1", cn); end
    checks++; if (addr !== 8'h10) begin failures++; $display("FAIL cache_first_addr got %h exp 10", addr); end
    do_fetch(3, 0, 0, 16'h9000, 1, lat, cn, dn);
`ifdef PIXFETCH_WORD_CACHE_EN
    checks++; if (cn !== 0) begin failures++; $display("FAIL cache_hit_csb got %0d exp 0", cn); end
    checks++; if (p !== 4'hB) begin failures++; $display("FAIL cache_hit_p got %h exp b", p); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL cache_hit_latency got %0d exp 2", lat); end
`else
    checks++; if (cn !== 1) begin failures++; $display("FAIL nocache_csb got %0d exp 1", cn); end
    checks++; if (p !== 4'h9) begin failures++; $display("FAIL nocache_p got %h exp 9", p); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL nocache_latency got %0d exp 4", lat); end
`endif
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cache_err got %b exp 0", err); end
  endtask

  initial begin
    test_reset();
    test_basic(1, 2, 1, 16'hA5C3, 8'h16, 4'hC);
    test_out_of_range(4, 0, 0);
    test_out_of_range(0, 0, -1);
    test_out_of_range(0, 0, 3);
    test_timeout();
    test_basic(3, 3, 2, 16'h5DEF, 8'h1B, 4'h5);
    test_edge_handling();
    test_reset_during_wait();
    test_cache();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
